// File: rtl/cpu_ext_pkg.sv
// cpu_ext_pkg
// Shared definitions for the cpu_ext core: opcode encoding, bit positions
// of the {V,N,Z,C} flag nibble, and the MUL sequencer state encoding.
package cpu_ext_pkg;

  typedef enum logic [3:0] {
    OP_MVR = 4'h0,
    OP_LDB = 4'h1,
    OP_STB = 4'h2,
    OP_RDS = 4'h3,
    OP_MUL = 4'h4,
    OP_SHL = 4'h5,
    OP_SHR = 4'h6,
    OP_NOP = 4'h7,
    OP_CLR = 4'h8,
    OP_AND = 4'h9,
    OP_ORA = 4'hA,
    OP_ADD = 4'hB,
    OP_SUB = 4'hC,
    OP_XOR = 4'hD,
    OP_INC = 4'hE,
    OP_NOT = 4'hF
  } op_e;

  localparam int FLAGS_W = 4;
  localparam int FLAG_C  = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 2;
  localparam int FLAG_V  = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/cpu_ext_alu.sv
// cpu_ext_alu
// Purely combinational single-cycle execution unit. Produces the register
// write value, whether the register file and/or flags should be written,
// and the new flag nibble. MUL, STB, RDS and NOP produce no writes here.
// Ports:
//   op_i      opcode
//   rb_val_i  source 1 operand
//   rc_val_i  source 2 operand
//   imm_i     immediate for LDB
//   result_o  value to write into ra
//   wr_en_o   ra should be written
//   flags_en_o flags should be updated
//   flags_o   new {V,N,Z,C}
module cpu_ext_alu
  import cpu_ext_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]         op_i,
  input  logic [DATA_W-1:0]  rb_val_i,
  input  logic [DATA_W-1:0]  rc_val_i,
  input  logic [DATA_W-1:0]  imm_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               wr_en_o,
  output logic               flags_en_o,
  output logic [FLAGS_W-1:0] flags_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] add_ext;
  logic [DATA_W:0] sub_ext;
  logic [DATA_W:0] inc_ext;
  logic            carry;
  logic            ovf;

  // One extra bit on each adder captures carry-out / borrow.
  assign add_ext = {1'b0, rb_val_i} + {1'b0, rc_val_i};
  assign sub_ext = {1'b0, rb_val_i} - {1'b0, rc_val_i};
  assign inc_ext = {1'b0, rb_val_i} + (DATA_W + 1)'(1);

  always_comb begin
    result_o   = '0;
    wr_en_o    = 1'b0;
    flags_en_o = 1'b0;
    carry      = 1'b0;
    ovf        = 1'b0;
    case (op_e'(op_i))
      OP_MVR: begin
        result_o = rb_val_i;
        wr_en_o  = 1'b1;
      end
      OP_LDB: begin
        result_o = imm_i;
        wr_en_o  = 1'b1;
      end
      OP_CLR: begin
        wr_en_o = 1'b1;
      end
      OP_SHL: begin
        result_o   = {rb_val_i[MSB-1:0], 1'b0};
        carry      = rb_val_i[MSB];
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_SHR: begin
        result_o   = {1'b0, rb_val_i[MSB:1]};
        carry      = rb_val_i[0];
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_AND: begin
        result_o   = rb_val_i & rc_val_i;
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_ORA: begin
        result_o   = rb_val_i | rc_val_i;
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_XOR: begin
        result_o   = rb_val_i ^ rc_val_i;
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_NOT: begin
        result_o   = ~rb_val_i;
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_ADD: begin
        result_o   = add_ext[MSB:0];
        carry      = add_ext[DATA_W];
        // Overflow: like-signed operands giving an opposite-signed sum.
        ovf        = (rb_val_i[MSB] == rc_val_i[MSB]) && (add_ext[MSB] != rb_val_i[MSB]);
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_SUB: begin
        result_o   = sub_ext[MSB:0];
        carry      = sub_ext[DATA_W];  // borrow: rb < rc unsigned
        // Overflow: unlike-signed operands and result sign differs from rb.
        ovf        = (rb_val_i[MSB] != rc_val_i[MSB]) && (sub_ext[MSB] != rb_val_i[MSB]);
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      OP_INC: begin
        result_o   = inc_ext[MSB:0];
        carry      = inc_ext[DATA_W];
        ovf        = ~rb_val_i[MSB] & inc_ext[MSB];
        wr_en_o    = 1'b1;
        flags_en_o = 1'b1;
      end
      default: begin
        // STB, RDS, NOP and MUL do not write through this unit.
      end
    endcase
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_N] = result_o[MSB];
    flags_o[FLAG_V] = ovf;
  end

endmodule

// File: rtl/cpu_ext_core.sv
// cpu_ext_core
// Small register-machine execution core. Accepts one instruction per cycle
// while idle; single-cycle ops complete on the accepting edge, MUL runs a
// DATA_W-cycle shift-add sequence during which no instruction is accepted.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   instr_valid/ready      instruction handshake (ready only when idle)
//   instr_op               opcode
//   instr_ra/rb/rc         destination / source1 / source2 register index
//   instr_imm              immediate for LDB
//   out_valid              one-cycle pulse when out_data was reloaded
//   out_data               STB / RDS result
//   flags                  {V,N,Z,C}
//   busy                   MUL in progress
module cpu_ext_core
  import cpu_ext_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 16,
  parameter int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [3:0]         instr_op,
  input  logic [REG_AW-1:0]  instr_ra,
  input  logic [REG_AW-1:0]  instr_rb,
  input  logic [REG_AW-1:0]  instr_rc,
  input  logic [DATA_W-1:0]  instr_imm,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [FLAGS_W-1:0] flags,
  output logic               busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  op_e                 op_sel;
  logic                accept;

  state_e              state_q, state_d;

  logic [DATA_W-1:0]   regs_q [REG_COUNT];
  logic [DATA_W-1:0]   ra_val, rb_val, rc_val;

  logic [FLAGS_W-1:0]  flags_q, flags_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [REG_AW-1:0]   mul_dest_q;
  logic [2*DATA_W-1:0] prod_step;
  logic                mul_last;
  logic                mul_start;
  logic [FLAGS_W-1:0]  mul_flags;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_wr_en;
  logic                alu_flags_en;
  logic [FLAGS_W-1:0]  alu_flags;

  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  assign op_sel    = op_e'(instr_op);
  assign accept    = instr_valid && instr_ready;
  assign mul_start = accept && (op_sel == OP_MUL);

  // Register reads: indices that match no implemented register read as 0.
  always_comb begin
    ra_val = '0;
    rb_val = '0;
    rc_val = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (instr_ra == REG_AW'(i)) ra_val = regs_q[i];
      if (instr_rb == REG_AW'(i)) rb_val = regs_q[i];
      if (instr_rc == REG_AW'(i)) rc_val = regs_q[i];
    end
  end

  cpu_ext_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op_i      (instr_op),
    .rb_val_i  (rb_val),
    .rc_val_i  (rc_val),
    .imm_i     (instr_imm),
    .result_o  (alu_result),
    .wr_en_o   (alu_wr_en),
    .flags_en_o(alu_flags_en),
    .flags_o   (alu_flags)
  );

  // ---------------- MUL sequencer FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (mul_start) state_d = ST_MUL_RUN;
      ST_MUL_RUN: if (mul_last)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    busy        = (state_q == ST_MUL_RUN);
  end

  // ---------------- MUL datapath ----------------
  // One partial product per cycle; the final edge consumes prod_step
  // directly so the result lands exactly DATA_W edges after accept.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last  = (state_q == ST_MUL_RUN) && (cnt_q == CNT_LAST);

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_C] = (prod_step[2*DATA_W-1:DATA_W] != '0);
    mul_flags[FLAG_Z] = (prod_step[DATA_W-1:0] == '0);
    mul_flags[FLAG_N] = prod_step[DATA_W-1];
  end

  // Operands are captured at accept so instruction inputs may change freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      mul_dest_q <= '0;
    end else if (mul_start) begin
      mcand_q    <= {{DATA_W{1'b0}}, rb_val};
      mplier_q   <= rc_val;
      prod_q     <= '0;
      cnt_q      <= '0;
      mul_dest_q <= instr_ra;
    end else if (state_q == ST_MUL_RUN) begin
      mcand_q  <= {mcand_q[2*DATA_W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
      prod_q   <= prod_step;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------- Register file ----------------
  // Accept and MUL completion are mutually exclusive (no accept while busy).
  assign rf_we    = (accept && alu_wr_en) || mul_last;
  assign rf_waddr = mul_last ? mul_dest_q : instr_ra;
  assign rf_wdata = mul_last ? prod_step[DATA_W-1:0] : alu_result;

  // Writes to indices with no backing register simply match nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (rf_waddr == REG_AW'(i)) regs_q[i] <= rf_wdata;
      end
    end
  end

  // ---------------- Flags and output port ----------------
  always_comb begin
    flags_d = flags_q;
    if (accept && alu_flags_en) flags_d = alu_flags;
    else if (mul_last)          flags_d = mul_flags;
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (accept && (op_sel == OP_STB)) begin
      out_valid_d = 1'b1;
      out_data_d  = ra_val;
    end else if (accept && (op_sel == OP_RDS)) begin
      out_valid_d = 1'b1;
      out_data_d  = DATA_W'(flags_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign flags     = flags_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cpu_ext_core.sv
module tb_cpu_ext_core;
  import cpu_ext_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default 8-bit, 16-register instance
  logic        iv = 1'b0;
  logic [3:0]  iop = '0;
  logic [3:0]  ira = '0, irb = '0, irc = '0;
  logic [7:0]  iimm = '0;
  logic        instr_ready, out_valid, busy;
  logic [7:0]  out_data;
  logic [3:0]  flags;

  // 16-bit, 4-register instance with 3-bit indices (r4..r7 unimplemented)
  logic        jv = 1'b0;
  logic [3:0]  jop = '0;
  logic [2:0]  jra = '0, jrb = '0, jrc = '0;
  logic [15:0] jimm = '0;
  logic        j_ready, j_out_valid, j_busy;
  logic [15:0] j_out_data;
  logic [3:0]  j_flags;

  cpu_ext_core u_dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(iv), .instr_ready(instr_ready), .instr_op(iop),
    .instr_ra(ira), .instr_rb(irb), .instr_rc(irc), .instr_imm(iimm),
    .out_valid(out_valid), .out_data(out_data), .flags(flags), .busy(busy)
  );

  cpu_ext_core #(.DATA_W(16), .REG_COUNT(4), .REG_AW(3)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(jv), .instr_ready(j_ready), .instr_op(jop),
    .instr_ra(jra), .instr_rb(jrb), .instr_rc(jrc), .instr_imm(jimm),
    .out_valid(j_out_valid), .out_data(j_out_data), .flags(j_flags), .busy(j_busy)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp16_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- Stimulus helpers (8-bit) ----------------
  task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic [7:0] imm);
    int w;
    w = 0;
    @(negedge clk);
    iv = 1'b1; iop = op; ira = ra; irb = rb; irc = rc; iimm = imm;
    while (!instr_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout8: got ready=0 required ready=1 within 64 cycles");
    end
    @(posedge clk);
    #1 iv = 1'b0;
    $display("issue8  op=%0h ra=%0d rb=%0d rc=%0d imm=0x%0h", op, ra, rb, rc, imm);
  endtask

  task automatic ldb(input logic [3:0] ra, input logic [7:0] imm);
    issue(OP_LDB, ra, 4'd0, 4'd0, imm);
  endtask

  task automatic op3(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    issue(op, ra, rb, rc, 8'h00);
  endtask

  task automatic stb(input logic [3:0] ra, input logic [7:0] expv);
    exp_q.push_back(expv);
    issue(OP_STB, ra, 4'd0, 4'd0, 8'h00);
  endtask

  task automatic rds(input logic [7:0] expv);
    exp_q.push_back(expv);
    issue(OP_RDS, 4'd0, 4'd0, 4'd0, 8'h00);
  endtask

  // ---------------- Stimulus helpers (16-bit) ----------------
  task automatic issue16(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rc, input logic [15:0] imm, input logic push,
                         input logic [15:0] expv);
    int w;
    w = 0;
    if (push) exp16_q.push_back(expv);
    @(negedge clk);
    jv = 1'b1; jop = op; jra = ra; jrb = rb; jrc = rc; jimm = imm;
    while (!j_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!j_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout16: got ready=0 required ready=1 within 64 cycles");
    end
    @(posedge clk);
    #1 jv = 1'b0;
    $display("issue16 op=%0h ra=%0d rb=%0d rc=%0d imm=0x%0h", op, ra, rb, rc, imm);
  endtask

  // ---------------- Monitors / scoreboards ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out8_unexpected: got 0x%0h required no output", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("out8    data=0x%0h expected=0x%0h", out_data, e);
        check("out8", {24'd0, out_data}, {24'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && j_out_valid) begin
      if (exp16_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out16_unexpected: got 0x%0h required no output", j_out_data);
      end else begin
        logic [15:0] e;
        e = exp16_q.pop_front();
        $display("out16   data=0x%0h expected=0x%0h", j_out_data, e);
        check("out16", {16'd0, j_out_data}, {16'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- Directed sequence ----------------
  initial begin
    int low;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_flags",     {28'd0, flags},     32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_out16",     {16'd0, j_out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    // ADD with signed overflow: 0x7F + 0x01
    ldb(4'd1, 8'h7F);
    ldb(4'd2, 8'h01);
    op3(OP_ADD, 4'd3, 4'd1, 4'd2);
    stb(4'd3, 8'h80);
    rds(8'h0C);

    // INC wrap: 0xFF + 1, single-cycle out_valid pulse
    ldb(4'd1, 8'hFF);
    op3(OP_INC, 4'd2, 4'd1, 4'd0);
    check("inc_flags", {28'd0, flags}, 32'h3);
    stb(4'd2, 8'h00);
    @(negedge clk);
    check("stb_pulse_hi", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("stb_pulse_lo", {31'd0, out_valid}, 32'd0);
    check("stb_data_hold", {24'd0, out_data}, 32'd0);
    rds(8'h03);

    // Shifts, logic ops, MVR leaving flags alone
    ldb(4'd1, 8'h81);
    op3(OP_SHL, 4'd2, 4'd1, 4'd0);
    stb(4'd2, 8'h02);
    rds(8'h01);
    op3(OP_SHR, 4'd3, 4'd1, 4'd0);
    stb(4'd3, 8'h40);
    op3(OP_XOR, 4'd4, 4'd1, 4'd1);
    rds(8'h02);
    op3(OP_NOT, 4'd5, 4'd4, 4'd0);
    op3(OP_MVR, 4'd6, 4'd5, 4'd0);
    stb(4'd6, 8'hFF);
    rds(8'h04);

    // SUB borrow, CLR does not touch flags
    ldb(4'd5, 8'h03);
    op3(OP_SUB, 4'd6, 4'd0, 4'd5);
    stb(4'd6, 8'hFD);
    rds(8'h05);
    op3(OP_CLR, 4'd6, 4'd0, 4'd0);
    stb(4'd6, 8'h00);
    rds(8'h05);

    // MUL 0x10 * 0x12 = 0x120; STB held during busy with changed fields
    ldb(4'd1, 8'h10);
    ldb(4'd2, 8'h12);
    op3(OP_MUL, 4'd3, 4'd1, 4'd2);
    @(negedge clk);
    check("mul_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(8'h20);
    iv = 1'b1; iop = OP_STB; ira = 4'd3; irb = 4'd7; irc = 4'd9;
    low = 0;
    while (!instr_ready && low < 50) begin
      low++;
      @(negedge clk);
    end
    check("mul_ready_low_cycles", low, 32'd8);
    @(posedge clk);
    #1 iv = 1'b0;
    $display("issue8  op=2 ra=3 (held through MUL)");
    rds(8'h01);

    // Reset in the middle of a MUL
    op3(OP_MUL, 4'd3, 4'd1, 4'd2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    stb(4'd3, 8'h00);
    stb(4'd1, 8'h00);
    rds(8'h00);

    // 16-bit, 4-register build
    issue16(OP_LDB, 3'd7, 3'd0, 3'd0, 16'hFFFF, 1'b0, 16'h0);
    issue16(OP_STB, 3'd7, 3'd0, 3'd0, 16'h0, 1'b1, 16'h0000);
    issue16(OP_LDB, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b0, 16'h0);
    issue16(OP_LDB, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0, 16'h0);
    issue16(OP_STB, 3'd1, 3'd0, 3'd0, 16'h0, 1'b1, 16'hFFFF);
    issue16(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0, 1'b0, 16'h0);
    issue16(OP_STB, 3'd3, 3'd0, 3'd0, 16'h0, 1'b1, 16'h0000);
    issue16(OP_RDS, 3'd0, 3'd0, 3'd0, 16'h0, 1'b1, 16'h0003);

    repeat (4) @(negedge clk);
    check("pending8",  exp_q.size(),   32'd0);
    check("pending16", exp16_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
